lsu: RTL
========

# lsu

Load/store unit sitting directly upstream of `dmem` in the single-cycle core's data path. Accepts one load or store request at a time from the core over a valid/ready handshake and drives `dmem`'s address, write-data, write-enable and size pins. Sign- or zero-extends load data and returns the result as a one-cycle response pulse. Detects misaligned and reserved-size accesses and faults them, or splits misaligned accesses into byte accesses when configured to.

## Interface
Parameters:
- `ADDR_W`, 32, address width; bit 0 is the MSB, big-endian bit numbering throughout.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock, shared with `dmem`
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  core presents a request
- `req_ready`  out  1  LSU can accept a request this cycle
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- `req_signed`  in  1  load sign-extends when 1
- `req_addr`  in  `ADDR_W`  byte address
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  one-cycle response pulse
- `resp_rdata`  out  32  extended load data; 0 for stores and faults
- `resp_fault`  out  1  qualifies `resp_valid`; access rejected
- `mem_addr`  out  `ADDR_W`  to `dmem` `addr`
- `mem_wdata`  out  32  to `dmem` `wData`, right-justified
- `mem_write`  out  1  to `dmem` `writeEnable`
- `mem_dsize`  out  2  to `dmem` `dsize`, same encoding as `req_size`
- `mem_rdata`  in  32  from `dmem` `rData`, combinational and right-justified with upper bits zero

## Operation
- States: IDLE, ACCESS, SPLIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, capture all request fields into registers.
  - Go to ACCESS if the request is aligned and size ≠ 11.
  - Otherwise go to SPLIT if split is enabled and size ≠ 11.
  - Otherwise go to RESP with the fault flag set.
- **Alignment** (bits are LSBs):
  - Half: misaligned if `addr[31]` = 1.
  - Word: misaligned if `addr[30:31]` ≠ 00.
  - Byte: always aligned.
- **ACCESS**
  - Drive `mem_*` from the captured registers.
  - `mem_write` = captured write flag, asserted for exactly this one cycle.
  - Loads latch `mem_rdata` into the result register at the end of the cycle.
  - Next state: RESP.
- **SPLIT**
  - Issues n byte accesses, n = 2 (half) or 4 (word), one per cycle, using a 2-bit counter k.
  - `mem_addr` = base + k; `mem_dsize` = 00.
  - Store byte k = `wdata` byte (4−n+k); that is, right-justified data is sent big-endian, MSB at the lowest address.
  - Load: result = (result << 8) | `mem_rdata[24:31]`.
  - Address arithmetic wraps modulo 2^`ADDR_W`.
  - After access k = n−1, go to RESP.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle; then IDLE.
  - Load: `resp_rdata` = result extended from 8, 16 or 32 bits, by `req_signed`.
  - Store: `resp_rdata` = 0.
  - Fault: `resp_fault` = 1, `resp_rdata` = 0, and `mem_write` is never asserted for the request.
- **Outside ACCESS/SPLIT**: `mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_dsize` = 00.
- **Backpressure**: `req_ready` = 0 outside IDLE. No backpressure on the response; the core must consume `resp_valid` when it occurs.
- **Reset**, including mid-operation: state goes to IDLE immediately. The pending request is dropped with no response, and a partially split store leaves already-written bytes in place.
- Reset values: `req_ready` = 1, `resp_valid` = 0, `resp_fault` = 0, `resp_rdata` = 0, all `mem_*` = 0.

## Timing
- Request accepted at edge E0.
- Aligned access: ACCESS during cycle after E0; `resp_valid` during the cycle after E1; `req_ready` high again after E2. Throughput is one request per 3 cycles.
- Split access: n access cycles, then RESP, giving latency n+1 edges to `resp_valid`.
- Fault: `resp_valid` in the cycle immediately after E0.
- `dmem` write commits on the edge ending the ACCESS/SPLIT cycle.

## Configuration
- `LSU_MISALIGN_SPLIT_EN`
  - Defined: misaligned half/word accesses are split into byte accesses as above; only size 11 faults.
  - Undefined: SPLIT state and counter are not built; every misaligned access faults.

## Structure
- Shared package `lsu_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_RSVD`
  - state enum `lsu_state_t`
  - a `size_bytes()` function
- One sub-module `lsu_extend`: combinational sign/zero extension, with inputs raw 32 bits, size and signed flag.

## Test plan
- Load word 0x2000 with `dmem` holding 0x11223344 → `resp_valid` two cycles after accept, `resp_rdata` = 0x11223344, `resp_fault` = 0.
- Signed byte load of 0x2001 holding 0x80 → `resp_rdata` = 0xFFFFFF80; the same load unsigned → 0x00000080.
- Store half 0xBEEF to 0x2002 → `mem_write` high for one cycle with `mem_dsize` = 01; a later word load of 0x2000 shows 0xBEEF in bits [16:31].
- Word load at 0x2001 without the macro → `resp_fault` = 1 and `resp_rdata` = 0 in the cycle after accept, with `mem_write` never high. With the macro and bytes 0xAA 0xBB 0xCC 0xDD at 0x2001–0x2004 → four byte accesses, then `resp_rdata` = 0xAABBCCDD.
- Size 11 request → fault in both configurations.
- Assert `rst` during ACCESS of a store → `mem_write` drops immediately, no `resp_valid`, `req_ready` = 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states and
// small helpers. Bit numbering is big-endian (bit 0 is the MSB).
package lsu_pkg;

  localparam logic [0:1] SZ_BYTE = 2'b00;
  localparam logic [0:1] SZ_HALF = 2'b01;
  localparam logic [0:1] SZ_WORD = 2'b10;
  localparam logic [0:1] SZ_RSVD = 2'b11;

  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | single aligned dmem access
  // SPLIT  | one byte access per cycle for a misaligned half/word
  // RESP   | one-cycle response pulse
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  function automatic logic [2:0] size_bytes(input logic [0:1] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // lsbs are the two least significant address bits (addr[30:31])
  function automatic logic misaligned(input logic [0:1] size, input logic [0:1] lsbs);
    case (size)
      SZ_HALF: return lsbs[1];
      SZ_WORD: return lsbs != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus the dmem pin bundle driven by the LSU.
// The slave modport is the LSU side; the master modport is the core/dmem side.
interface lsu_if #(parameter int ADDR_W = 32);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [0:1]        req_size;
  logic              req_signed;
  logic [0:ADDR_W-1] req_addr;
  logic [0:31]       req_wdata;

  logic              resp_valid;
  logic [0:31]       resp_rdata;
  logic              resp_fault;

  logic [0:ADDR_W-1] mem_addr;
  logic [0:31]       mem_wdata;
  logic              mem_write;
  logic [0:1]        mem_dsize;
  logic [0:31]       mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_wdata, mem_write, mem_dsize
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_addr, mem_wdata, mem_write, mem_dsize
  );

endinterface

// File: rtl/lsu_extend.sv
// Combinational sign/zero extension of right-justified load data to 32 bits.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [0:31] raw,
  input  logic [0:1]  size,
  input  logic        sgn,
  output logic [0:31] ext
);

  // Replicate the top bit of the loaded field when signed, otherwise zero-fill
  always_comb begin
    ext = raw;
    case (size)
      SZ_BYTE: ext = {{24{sgn & raw[24]}}, raw[24:31]};
      SZ_HALF: ext = {{16{sgn & raw[16]}}, raw[16:31]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of dmem. One request at a time; aligned accesses
// take a single dmem cycle, reserved sizes fault. Misaligned half/word accesses
// fault unless LSU_MISALIGN_SPLIT_EN is defined, in which case they are issued
// as big-endian byte accesses (lowest address carries the most significant byte).
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  lsu_state_t  state;
  logic        r_write;
  logic        r_signed;
  logic [0:1]  r_size;
  logic        req_rsvd;
  logic        req_misal;
  logic [0:31] ext_raw;
  logic [0:31] ext_out;

  assign req_rsvd  = bus.req_size == SZ_RSVD;
  assign req_misal = misaligned(bus.req_size, bus.req_addr[ADDR_W-2:ADDR_W-1]);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]  k;
  logic [1:0]  k_last;
  logic [0:31] result;
  logic [0:31] result_nxt;
  logic [0:31] split_data;
  logic [0:31] sh;

  // Left-justify the store bytes so byte 0 of the split sequence sits at bits [0:7]
  assign split_data = (bus.req_size == SZ_HALF) ? (bus.req_wdata << 16) : bus.req_wdata;
  assign result_nxt = {result[8:31], bus.mem_rdata[24:31]};
  assign k_last     = 2'(size_bytes(r_size) - 3'd1);
  // On the last split byte the accumulated value goes straight to the extender
  assign ext_raw    = (state == SPLIT) ? result_nxt : bus.mem_rdata;
`else
  assign ext_raw    = bus.mem_rdata;
`endif

  lsu_extend u_extend (
    .raw  (ext_raw),
    .size (r_size),
    .sgn  (r_signed),
    .ext  (ext_out)
  );

  // Request FSM; all handshake and dmem pins are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      r_write        <= 1'b0;
      r_signed       <= 1'b0;
      r_size         <= SZ_BYTE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_fault <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_write  <= 1'b0;
      bus.mem_dsize  <= SZ_BYTE;
`ifdef LSU_MISALIGN_SPLIT_EN
      k              <= '0;
      result         <= '0;
      sh             <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_write       <= bus.req_write;
            r_signed      <= bus.req_signed;
            r_size        <= bus.req_size;
            bus.req_ready <= 1'b0;
            if (!req_rsvd && !req_misal) begin
              state         <= ACCESS;
              bus.mem_addr  <= bus.req_addr;
              bus.mem_wdata <= bus.req_wdata;
              bus.mem_write <= bus.req_write;
              bus.mem_dsize <= bus.req_size;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            else if (!req_rsvd) begin
              state         <= SPLIT;
              k             <= '0;
              result        <= '0;
              sh            <= split_data << 8;
              bus.mem_addr  <= bus.req_addr;
              bus.mem_wdata <= {24'h0, split_data[0:7]};
              bus.mem_write <= bus.req_write;
              bus.mem_dsize <= SZ_BYTE;
            end
`endif
            else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_fault <= 1'b1;
              bus.resp_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          state          <= RESP;
          bus.mem_addr   <= '0;
          bus.mem_wdata  <= '0;
          bus.mem_write  <= 1'b0;
          bus.mem_dsize  <= SZ_BYTE;
          bus.resp_valid <= 1'b1;
          bus.resp_fault <= 1'b0;
          bus.resp_rdata <= r_write ? '0 : ext_out;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        SPLIT: begin
          result <= result_nxt;
          if (k == k_last) begin
            state          <= RESP;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_write  <= 1'b0;
            bus.mem_dsize  <= SZ_BYTE;
            bus.resp_valid <= 1'b1;
            bus.resp_fault <= 1'b0;
            bus.resp_rdata <= r_write ? '0 : ext_out;
          end else begin
            k             <= k + 2'd1;
            sh            <= sh << 8;
            bus.mem_addr  <= bus.mem_addr + ADDR_W'(1);
            bus.mem_wdata <= {24'h0, sh[0:7]};
          end
        end
`endif
        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_fault <= 1'b0;
          bus.resp_rdata <= '0;
          bus.req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
